// File: rtl/reg_file_pkg.sv
// Shared constants, dump state encoding and the bypassed-read helper for reg_file.
package reg_file_pkg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_t;

  // R0 reads as zero; otherwise a same-cycle write to the address wins over the stored value.
  function automatic logic [WIDTH-1:0] bypass_read(
    input logic [AW-1:0]    addr,
    input logic             we,
    input logic [AW-1:0]    waddr,
    input logic [WIDTH-1:0] wdata,
    input logic [WIDTH-1:0] stored
  );
    if (addr == '0) begin
      return '0;
    end else if (we && (waddr == addr)) begin
      return wdata;
    end else begin
      return stored;
    end
  endfunction

endpackage

// File: rtl/reg_file_dump.sv
// Debug dump engine: walks every register index and presents each word over valid/ready.
//
// state | meaning
// IDLE  | no dump in progress, waiting for dump_start
// SEND  | dump_addr/dump_data hold a word waiting to be accepted
module reg_file_dump
  import reg_file_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             dump_start,
  input  logic             dump_ready,
  input  logic [WIDTH-1:0] rd_data,
  output logic [AW-1:0]    rd_addr,
  output logic             dump_valid,
  output logic [AW-1:0]    dump_addr,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_busy
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  dump_state_t state, state_next;
  logic        load;
  logic [AW-1:0] load_addr;

  // State register and the registered output word; the word only changes when a new index is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dump_addr <= '0;
      dump_data <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        dump_addr <= load_addr;
        dump_data <= rd_data;
      end
    end
  end

  // Next state and which index (if any) to capture; the capture index drives the shared read port.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_addr  = '0;
    unique case (state)
      IDLE: begin
        if (dump_start) begin
          state_next = SEND;
          load       = 1'b1;
          load_addr  = '0;
        end
      end
      SEND: begin
        if (dump_ready) begin
          if (dump_addr == LAST_ADDR) begin
            state_next = IDLE;
          end else begin
            load      = 1'b1;
            load_addr = dump_addr + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rd_addr    = load_addr;
  assign dump_valid = (state == SEND);
  assign dump_busy  = (state == SEND);

endmodule

// File: rtl/reg_file.sv
// 8x16 two-read one-write register file with R0 tied to zero, write-through bypass and a debug dump port.
module reg_file
  import reg_file_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  input  logic             dump_start,
  input  logic             dump_ready,
  output logic             dump_valid,
  output logic [AW-1:0]    dump_addr,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_busy
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [AW-1:0]    dump_rd_addr;
  logic [WIDTH-1:0] dump_rd_data;

  // Register array; R0 is never written so it stays zero from reset onward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1       = bypass_read(raddr1, we, waddr, wdata, regs[raddr1]);
  assign rdata2       = bypass_read(raddr2, we, waddr, wdata, regs[raddr2]);
  assign dump_rd_data = bypass_read(dump_rd_addr, we, waddr, wdata, regs[dump_rd_addr]);

  reg_file_dump u_dump (
    .clk        (clk),
    .rst        (rst),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .rd_data    (dump_rd_data),
    .rd_addr    (dump_rd_addr),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: read/write/bypass checks inline, dump words checked by a queue-driven monitor.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr1, raddr2;
  logic [15:0] rdata1, rdata2;
  logic        dump_start, dump_ready;
  logic        dump_valid, dump_busy;
  logic [2:0]  dump_addr;
  logic [15:0] dump_data;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
  } word_t;

  word_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  reg_file dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] a, input logic [15:0] d);
    word_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Monitor: every accepted dump word is compared against the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && dump_valid && dump_ready) begin
      if (exp_q.size() == 0) begin
        check("dump_unexpected_word", {29'd0, dump_addr}, 32'hFFFF_FFFF);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        check("dump_addr", {29'd0, dump_addr}, {29'd0, w.addr});
        check("dump_data", {16'd0, dump_data}, {16'd0, w.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0; dump_start = 1'b0; dump_ready = 1'b0;
    #1;
    check("rst_dump_valid", {31'd0, dump_valid}, 32'd0);
    check("rst_dump_busy",  {31'd0, dump_busy},  32'd0);
    check("rst_dump_addr",  {29'd0, dump_addr},  32'd0);
    check("rst_dump_data",  {16'd0, dump_data},  32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int a = 0; a < 8; a++) begin
      raddr1 = 3'(a); raddr2 = 3'(a); #1;
      check("reset_rdata1", {16'd0, rdata1}, 32'd0);
      check("reset_rdata2", {16'd0, rdata2}, 32'd0);
    end

    we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF;
    tick();
    we = 1'b0; raddr1 = 3'd3; raddr2 = 3'd3; #1;
    check("r3_port1", {16'd0, rdata1}, 32'h0000_BEEF);
    check("r3_port2", {16'd0, rdata2}, 32'h0000_BEEF);

    we = 1'b1; waddr = 3'd0; wdata = 16'h1234; raddr1 = 3'd0; #1;
    check("r0_no_bypass", {16'd0, rdata1}, 32'd0);
    tick();
    we = 1'b0; #1;
    check("r0_after_write", {16'd0, rdata1}, 32'd0);

    we = 1'b1; waddr = 3'd5; wdata = 16'hA5A5; raddr1 = 3'd3; raddr2 = 3'd5; #1;
    check("bypass_port2", {16'd0, rdata2}, 32'h0000_A5A5);
    check("other_port1",  {16'd0, rdata1}, 32'h0000_BEEF);
    tick();
    we = 1'b0; #1;
    check("r5_stored", {16'd0, rdata2}, 32'h0000_A5A5);

    for (int k = 1; k < 8; k++) begin
      we = 1'b1; waddr = 3'(k); wdata = 16'h1000 + 16'(k);
      tick();
    end
    we = 1'b0;

    // Full dump with ready held high.
    push(3'd0, 16'h0000);
    for (int k = 1; k < 8; k++) push(3'(k), 16'h1000 + 16'(k));
    dump_ready = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    check("dump_valid_rise", {31'd0, dump_valid}, 32'd1);
    repeat (7) tick();
    check("busy_before_last", {31'd0, dump_busy}, 32'd1);
    tick();
    check("busy_after_dump",  {31'd0, dump_busy},  32'd0);
    check("valid_after_dump", {31'd0, dump_valid}, 32'd0);
    check("queue_drained_1",  exp_q.size(), 32'd0);

    // Dump with a stall at word 2 and a write that lands on the next index during a transfer.
    push(3'd0, 16'h0000); push(3'd1, 16'h1001); push(3'd2, 16'h1002); push(3'd3, 16'h1003);
    push(3'd4, 16'h4444); push(3'd5, 16'h1005); push(3'd6, 16'h1006); push(3'd7, 16'h1007);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    tick(); tick();
    dump_ready = 1'b0;
    we = 1'b1; waddr = 3'd2; wdata = 16'hFFFF;
    tick();
    we = 1'b0;
    tick(); tick();
    check("stall_addr",  {29'd0, dump_addr},  32'd2);
    check("stall_data",  {16'd0, dump_data},  32'h0000_1002);
    check("stall_valid", {31'd0, dump_valid}, 32'd1);
    dump_ready = 1'b1;
    tick();
    we = 1'b1; waddr = 3'd4; wdata = 16'h4444;
    tick();
    we = 1'b0;
    repeat (4) tick();
    check("busy_after_dump2", {31'd0, dump_busy}, 32'd0);
    check("queue_drained_2",  exp_q.size(), 32'd0);

    // Reset while word 5 is presented.
    push(3'd0, 16'h0000); push(3'd1, 16'h1001); push(3'd2, 16'hFFFF);
    push(3'd3, 16'h1003); push(3'd4, 16'h4444);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    repeat (5) tick();
    check("pre_rst_addr", {29'd0, dump_addr}, 32'd5);
    check("pre_rst_data", {16'd0, dump_data}, 32'h0000_1005);
    rst = 1'b1; #1;
    check("mid_rst_valid", {31'd0, dump_valid}, 32'd0);
    check("mid_rst_busy",  {31'd0, dump_busy},  32'd0);
    check("mid_rst_addr",  {29'd0, dump_addr},  32'd0);
    check("mid_rst_data",  {16'd0, dump_data},  32'd0);
    check("queue_drained_3", exp_q.size(), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) begin
      raddr1 = 3'(a); raddr2 = 3'(7 - a); #1;
      check("post_rst_rdata1", {16'd0, rdata1}, 32'd0);
      check("post_rst_rdata2", {16'd0, rdata2}, 32'd0);
    end

    // Zero dump after reset, then a back-to-back dump started on the first idle cycle.
    for (int k = 0; k < 8; k++) push(3'(k), 16'h0000);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    repeat (8) tick();
    check("busy_after_zero_dump", {31'd0, dump_busy}, 32'd0);
    for (int k = 0; k < 8; k++) push(3'(k), 16'h0000);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    check("b2b_valid", {31'd0, dump_valid}, 32'd1);
    repeat (8) tick();
    check("busy_after_b2b",  {31'd0, dump_busy}, 32'd0);
    check("queue_drained_4", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Two-read, one-write register file for the single-cycle processor datapath: 8 × 16-bit registers, R0 hardwired to zero, with write-through bypass on both read ports. It also has a debug dump port that streams every register out over a valid/ready handshake. The decode stage drives the read ports, writeback drives the write port, and the testbench or debug logic drives the dump port.

## Interface
- WIDTH, 16, data width of each register
- DEPTH, 8, number of registers; address width AW = log2(DEPTH) = 3
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- raddr1  in  AW  read port 1 address
- raddr2  in  AW  read port 2 address
- rdata1  out  WIDTH  read port 1 data (combinational)
- rdata2  out  WIDTH  read port 2 data (combinational)
- dump_start  in  1  request a full register dump
- dump_ready  in  1  consumer accepts the current dump word
- dump_valid  out  1  dump word present
- dump_addr  out  AW  index of the current dump word
- dump_data  out  WIDTH  contents of register dump_addr
- dump_busy  out  1  high while a dump is in progress

## Operation
- Reset (async): all registers = 0, FSM = IDLE, dump_valid/dump_busy = 0, dump_addr = 0, dump_data = 0.
- Write: on posedge with we=1 and waddr≠0, regs[waddr] ← wdata. Writes to R0 are discarded.
- Read: rdataN = 0 if raddrN = 0.
  - Otherwise, if we=1 and waddr = raddrN, then rdataN = wdata (bypass).
  - Otherwise rdataN = regs[raddrN].
  - Both ports are independent and may use the same address.
- Dump FSM, states IDLE and SEND:
  - IDLE: dump_start=1 moves to SEND. dump_addr ← 0; dump_data ← bypassed value of R0 (= 0).
  - SEND: dump_valid = dump_busy = 1. A transfer occurs on a cycle with dump_ready=1.
  - On transfer with dump_addr < DEPTH-1: dump_addr increments, and dump_data ← bypassed read of the new index. A write to that index in the same cycle is reflected.
  - On transfer with dump_addr = DEPTH-1: go to IDLE, with dump_valid and dump_busy low the next cycle.
  - dump_data and dump_addr are registered and stay stable while valid && !ready, even if that register is written meanwhile.
  - dump_start is ignored in SEND. Normal reads and writes are unaffected by a dump.

## Timing
- Read latency 0 (combinational). Write visible via the array the cycle after the posedge; visible on the same cycle through bypass.
- Dump: dump_valid rises 1 cycle after dump_start is sampled. With dump_ready held high, a full dump is DEPTH consecutive valid cycles and dump_busy drops the cycle after the last word.
- Handshake: once dump_valid is asserted, it stays asserted until transfer. dump_ready may toggle freely; stalls are unbounded.
- Reset mid-dump: outputs go to reset values immediately; no partial resume.
- Back-to-back: a dump_start in the first IDLE cycle after a dump completes begins a new dump.

## Structure
- Package reg_file_pkg:
  - WIDTH and DEPTH defaults, plus AW as a derived constant.
  - Dump state enum {IDLE, SEND}.
- Natural sub-module reg_file_dump. It holds the FSM, the index counter and the output registers, and reads the array through a shared bypassed-read function or port.
- The array and bypass logic stay in reg_file.

## Test plan
- Reset then read all addresses on both ports -> rdata1 = rdata2 = 0x0000.
- Write R3=0xBEEF, next cycle raddr1=3, raddr2=3 -> both 0xBEEF. Write R0=0x1234, then read R0 -> 0x0000.
- Bypass: we=1, waddr=5, wdata=0xA5A5 with raddr2=5 in the same cycle -> rdata2 = 0xA5A5 before the edge.
- Load Rk = 0x1000+k for k=1..7, pulse dump_start, ready held high -> 8 words, addr 0..7, data 0, 0x1001..0x1007 on consecutive cycles. dump_busy falls after word 7.
- Dump with ready low for 3 cycles at addr 2 while R2 is written 0xFFFF -> dump_data holds 0x1002 until transfer. Then write R4=0x4444 during the transfer of word 3 -> word 4 = 0x4444.
- Assert rst during word 5 of a dump -> dump_valid and dump_busy drop immediately, all registers read 0. A new dump_start after reset streams zeros.
